// File: rtl/mask_stream_gen_pkg.sv
// Shared types for the Cr-threshold mask stream generator and its frame tracker.
// Latency: n/a (types and constants only).
// Backpressure: n/a (types and constants only).
package mask_pkg;

    typedef logic [10:0] hcount_t;
    typedef logic [9:0]  vcount_t;

    typedef enum logic [1:0] {
        WAIT_SOF,
        IN_FRAME,
        FLUSH1,
        FLUSH2
    } fsm_t;

    localparam int HIT_CNT_W = 20;

endpackage

// File: rtl/mask_stream_gen_if.sv
// Pixel-in / hit-out bundle between the camera front end and mask_stream_gen.
// Latency: n/a (wiring only); master drives pixels, slave returns hits.
// Backpressure: none; MASK_HIT_COUNT_EN adds the per-frame hit count.
interface mask_stream_gen_if #(
    parameter int CHAN_W = 8
);
    import mask_pkg::*;

    hcount_t             hcount_in;
    vcount_t             vcount_in;
    logic                pixel_valid_in;
    logic [CHAN_W-1:0]   cr_in;
    logic [CHAN_W-1:0]   lower_in;
    logic [CHAN_W-1:0]   upper_in;
    hcount_t             x_out;
    vcount_t             y_out;
    logic                valid_out;
    logic                tabulate_out;
`ifdef MASK_HIT_COUNT_EN
    logic [HIT_CNT_W-1:0] hit_count_out;

    modport master (
        output hcount_in, vcount_in, pixel_valid_in, cr_in, lower_in, upper_in,
        input  x_out, y_out, valid_out, tabulate_out, hit_count_out
    );
    modport slave (
        input  hcount_in, vcount_in, pixel_valid_in, cr_in, lower_in, upper_in,
        output x_out, y_out, valid_out, tabulate_out, hit_count_out
    );
`else
    modport master (
        output hcount_in, vcount_in, pixel_valid_in, cr_in, lower_in, upper_in,
        input  x_out, y_out, valid_out, tabulate_out
    );
    modport slave (
        input  hcount_in, vcount_in, pixel_valid_in, cr_in, lower_in, upper_in,
        output x_out, y_out, valid_out, tabulate_out
    );
`endif

endinterface

// File: rtl/mask_stream_gen_frame_tracker.sv
// Frame FSM: SOF/EOF decode, abort-on-restart, 2-cycle drain, 1-cycle tabulate pulse.
// Latency: tabulate_o rises 3 cycles after the last pixel of a complete frame.
// Backpressure: none; pixels during the drain or outside a frame are not accepted.
module frame_tracker
    import mask_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic    clk_in,
    input  logic    rst_in,
    input  logic    pixel_valid_in,
    input  hcount_t hcount_in,
    input  vcount_t vcount_in,
    output logic    sof_o,
    output logic    accept_o,
    output logic    tab_next_o,
    output logic    tabulate_o
);

    localparam hcount_t H_LAST = hcount_t'(H_ACTIVE - 1);
    localparam vcount_t V_LAST = vcount_t'(V_ACTIVE - 1);

    fsm_t state_d, state_q;
    logic tab_d, tab_q;
    logic at_origin, at_last;

    // Decode frame boundaries and pick the next state; a restart at (0,0) beats the end-of-frame path.
    always_comb begin
        at_origin  = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
        at_last    = pixel_valid_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);
        sof_o      = at_origin && ((state_q == WAIT_SOF) || (state_q == IN_FRAME));
        accept_o   = sof_o || (pixel_valid_in && (state_q == IN_FRAME));
        state_d    = state_q;
        case (state_q)
            WAIT_SOF: if (sof_o) state_d = IN_FRAME;
            IN_FRAME: if (!sof_o && at_last) state_d = FLUSH1;
            FLUSH1:   state_d = FLUSH2;
            FLUSH2:   state_d = WAIT_SOF;
            default:  state_d = WAIT_SOF;
        endcase
        tab_d      = (state_q == FLUSH2);
        tab_next_o = tab_d;
        tabulate_o = tab_q;
    end

    // State and pulse registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= WAIT_SOF;
            tab_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tab_q   <= tab_d;
        end
    end

endmodule

// File: rtl/mask_stream_gen.sv
// Thresholds Cr per pixel and emits (x,y) of in-band pixels plus a per-frame tabulate pulse.
// Latency: 2 cycles pixel -> valid_out; tabulate 3 cycles after the frame's last pixel.
// Backpressure: none (always accepts). Optional MASK_HIT_COUNT_EN adds hit_count_out.
module mask_stream_gen
    import mask_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int CHAN_W   = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    mask_stream_gen_if.slave  bus
);

    logic              sof, accept, tab_next, tabulate;
    logic [CHAN_W-1:0] lo_d, lo_q, hi_d, hi_q;
    hcount_t           x1_d, x1_q, x_d, x_q;
    vcount_t           y1_d, y1_q, y_d, y_q;
    logic              hit1_d, hit1_q, vld_d, vld_q;

    frame_tracker #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_frame_tracker (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .pixel_valid_in (bus.pixel_valid_in),
        .hcount_in      (bus.hcount_in),
        .vcount_in      (bus.vcount_in),
        .sof_o          (sof),
        .accept_o       (accept),
        .tab_next_o     (tab_next),
        .tabulate_o     (tabulate)
    );

    // Stage 1: latch thresholds at SOF (the SOF pixel already uses the new band) and classify the pixel.
    always_comb begin
        lo_d   = sof ? bus.lower_in : lo_q;
        hi_d   = sof ? bus.upper_in : hi_q;
        hit1_d = accept && (bus.cr_in >= lo_d) && (bus.cr_in <= hi_d);
        x1_d   = accept ? bus.hcount_in : x1_q;
        y1_d   = accept ? bus.vcount_in : y1_q;
    end

    // Stage 2: present hits; coordinates hold their last hit when nothing is valid.
    always_comb begin
        vld_d = hit1_q;
        x_d   = hit1_q ? x1_q : x_q;
        y_d   = hit1_q ? y1_q : y_q;
    end

    // Pipeline and threshold registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lo_q   <= '0;
            hi_q   <= '0;
            hit1_q <= 1'b0;
            x1_q   <= '0;
            y1_q   <= '0;
            vld_q  <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            hit1_q <= hit1_d;
            x1_q   <= x1_d;
            y1_q   <= y1_d;
            vld_q  <= vld_d;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end

    assign bus.valid_out    = vld_q;
    assign bus.x_out        = x_q;
    assign bus.y_out        = y_q;
    assign bus.tabulate_out = tabulate;

`ifdef MASK_HIT_COUNT_EN
    logic [HIT_CNT_W-1:0] cnt_d, cnt_q, hc_d, hc_q;

    // Count output hits per frame; publish the total (including the last pixel's hit) with the tabulate pulse.
    always_comb begin
        cnt_d = cnt_q;
        if (sof)
            cnt_d = '0;
        else if (vld_q)
            cnt_d = cnt_q + 1'b1;
        hc_d  = tab_next ? cnt_d : hc_q;
    end

    // Hit counter and published count.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
            hc_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            hc_q  <= hc_d;
        end
    end

    assign bus.hit_count_out = hc_q;
`else
    logic unused_tab_next;
    assign unused_tab_next = tab_next;
`endif

endmodule

// File: tb/tb_mask_stream_gen.sv
// Bench for mask_stream_gen on a 4x3 raster: directed scenarios plus a randomized frame stream.
// Latency: expectations are pixel cycle +2 for hits and last pixel +3 for tabulate.
// Backpressure: none; the bench drives one pixel slot per cycle.
module tb_mask_stream_gen;
    import mask_pkg::*;

    localparam int H    = 4;
    localparam int V    = 3;
    localparam int LOGN = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mask_stream_gen_if #(.CHAN_W(8)) bus();

    mask_stream_gen #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .CHAN_W   (8)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output log, one entry per cycle, sampled mid-cycle.
    logic        log_vld[LOGN];
    logic        log_tab[LOGN];
    logic [10:0] log_x[LOGN];
    logic [9:0]  log_y[LOGN];
`ifdef MASK_HIT_COUNT_EN
    logic [19:0] log_hc[LOGN];
`endif
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            log_vld[cyc] = bus.valid_out;
            log_tab[cyc] = bus.tabulate_out;
            log_x[cyc]   = bus.x_out;
            log_y[cyc]   = bus.y_out;
`ifdef MASK_HIT_COUNT_EN
            log_hc[cyc]  = bus.hit_count_out;
`endif
        end
    end

    // Reference model: per-frame view of which pixels become hits and when frames complete.
    bit e_vld[LOGN];
    bit e_tab[LOGN];
    bit e_hcset[LOGN];
    int e_x[LOGN];
    int e_y[LOGN];
    int e_hc[LOGN];
    bit m_in_frame = 1'b0;
    int m_busy = 0;
    int m_lo = 0, m_hi = 0, m_cnt = 0;

    task automatic model_reset(input int k);
        for (int i = k + 1; i < LOGN; i++) begin
            e_vld[i] = 1'b0; e_tab[i] = 1'b0; e_hcset[i] = 1'b0;
        end
        m_in_frame = 1'b0;
        m_busy     = 0;
    endtask

    task automatic model_pixel(input int k, input bit pv, input int h, input int v,
                               input int cr, input int lo, input int up);
        if (!pv || k < m_busy || k + 3 >= LOGN) return;
        if (h == 0 && v == 0) begin
            m_in_frame = 1'b1; m_lo = lo; m_hi = up; m_cnt = 0;
        end
        if (!m_in_frame) return;
        if (cr >= m_lo && cr <= m_hi) begin
            e_vld[k+2] = 1'b1; e_x[k+2] = h; e_y[k+2] = v; m_cnt++;
        end
        if (h == H - 1 && v == V - 1) begin
            e_tab[k+3] = 1'b1; e_hcset[k+3] = 1'b1; e_hc[k+3] = m_cnt;
            m_in_frame = 1'b0; m_busy = k + 3;
        end
    endtask

    // Drive one pixel slot; optionally change upper_in in the same slot.
    task automatic px(input bit pv, input int h, input int v, input int cr, input int up = -1);
        @(posedge clk); #1;
        if (up >= 0) bus.upper_in = 8'(up);
        bus.pixel_valid_in = pv;
        bus.hcount_in      = 11'(h);
        bus.vcount_in      = 10'(v);
        bus.cr_in          = 8'(cr);
        if (!rst) model_pixel(cyc, pv, h, v, cr, int'(bus.lower_in), int'(bus.upper_in));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(1'b0, 0, 0, 0);
    endtask

    // Full raster, cr=99 except one chosen pixel; returns the SOF cycle.
    task automatic frame(input int hh, input int hv, input int hcr, input int new_up, output int s);
        s = 0;
        for (int v = 0; v < V; v++) begin
            for (int h = 0; h < H; h++) begin
                automatic int cr = (h == hh && v == hv) ? hcr : 99;
                if (h == 1 && v == 0 && new_up >= 0) px(1'b1, h, v, cr, new_up);
                else px(1'b1, h, v, cr);
                if (h == 0 && v == 0) s = cyc;
            end
        end
    endtask

    task automatic test_reset;
        int k;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.valid_out !== 1'b0 || bus.tabulate_out !== 1'b0 || bus.x_out !== 11'd0 || bus.y_out !== 10'd0) begin
            bad++; $display("FAIL reset_state got vld=%0b tab=%0b x=%0d y=%0d want all 0",
                            bus.valid_out, bus.tabulate_out, bus.x_out, bus.y_out);
        end
        px(1'b1, 0, 0, 120); px(1'b1, 1, 0, 120); px(1'b1, 2, 0, 120);
        @(posedge clk); #1 rst = 1'b1;
        bus.pixel_valid_in = 1'b1; bus.hcount_in = 11'd3; bus.vcount_in = 10'd0;
        model_reset(cyc); k = cyc;
        @(posedge clk); #1;
        bus.hcount_in = 11'd0; bus.vcount_in = 10'd1;
        model_reset(cyc);
        @(posedge clk); #1 rst = 1'b0; bus.pixel_valid_in = 1'b0;
        // Resume mid-frame without an SOF: nothing may come out.
        for (int i = 5; i < H * V; i++) px(1'b1, i % H, i / H, 120);
        idle(6);
        for (int c = k + 1; c < cyc; c++) begin
            total++;
            if (log_vld[c] !== 1'b0 || log_tab[c] !== 1'b0 || log_x[c] !== 11'd0 || log_y[c] !== 10'd0) begin
                bad++; $display("FAIL reset_nosof cyc=%0d got vld=%0b tab=%0b x=%0d y=%0d want 0 0 0 0",
                                c, log_vld[c], log_tab[c], log_x[c], log_y[c]);
            end
        end
`ifdef MASK_HIT_COUNT_EN
        total++;
        if (log_hc[k+1] !== 20'd0) begin
            bad++; $display("FAIL reset_hitcount got=%0d want=0", log_hc[k+1]);
        end
`endif
    endtask

    task automatic test_single_hit;
        int s, n;
        bus.lower_in = 8'd100; bus.upper_in = 8'd150;
        frame(2, 1, 150, -1, s);
        idle(6);
        n = 0;
        for (int c = s; c <= s + 15; c++) n += int'(log_vld[c]);
        total++;
        if (n !== 1) begin bad++; $display("FAIL single_hit_count got=%0d want=1", n); end
        total++;
        if (log_vld[s+8] !== 1'b1 || log_x[s+8] !== 11'd2 || log_y[s+8] !== 10'd1) begin
            bad++; $display("FAIL single_hit_slot got vld=%0b x=%0d y=%0d want 1 2 1",
                            log_vld[s+8], log_x[s+8], log_y[s+8]);
        end
        total++;
        if (log_x[s+12] !== 11'd2 || log_y[s+12] !== 10'd1) begin
            bad++; $display("FAIL single_hit_hold got x=%0d y=%0d want 2 1", log_x[s+12], log_y[s+12]);
        end
    endtask

    task automatic test_latency_tabulate;
        int s, n_end, n;
        frame(3, 2, 120, -1, s);
        idle(6);
        n_end = s + H * V - 1;
        total++;
        if (log_vld[n_end+2] !== 1'b1 || log_x[n_end+2] !== 11'd3 || log_y[n_end+2] !== 10'd2) begin
            bad++; $display("FAIL last_hit_slot got vld=%0b x=%0d y=%0d want 1 3 2",
                            log_vld[n_end+2], log_x[n_end+2], log_y[n_end+2]);
        end
        total++;
        if (log_tab[n_end+2] !== 1'b0 || log_tab[n_end+3] !== 1'b1 || log_tab[n_end+4] !== 1'b0) begin
            bad++; $display("FAIL tab_timing got N+2=%0b N+3=%0b N+4=%0b want 0 1 0",
                            log_tab[n_end+2], log_tab[n_end+3], log_tab[n_end+4]);
        end
        n = 0;
        for (int c = s; c <= n_end + 4; c++) n += int'(log_tab[c]);
        total++;
        if (n !== 1) begin bad++; $display("FAIL tab_count got=%0d want=1", n); end
    endtask

    task automatic test_abort;
        int a, s, nt, nv;
        px(1'b1, 0, 0, 120); a = cyc;
        for (int i = 1; i < 6; i++) px(1'b1, i % H, i / H, 99);
        idle(2);
        frame(1, 0, 120, -1, s);
        idle(6);
        nt = 0; nv = 0;
        for (int c = a; c < cyc; c++) begin
            nt += int'(log_tab[c]); nv += int'(log_vld[c]);
        end
        total++;
        if (nt !== 1 || log_tab[s+14] !== 1'b1) begin
            bad++; $display("FAIL abort_tab got count=%0d at_end=%0b want 1 1", nt, log_tab[s+14]);
        end
        total++;
        if (nv !== 2) begin bad++; $display("FAIL abort_hits got=%0d want=2", nv); end
    endtask

    task automatic test_threshold_change;
        int sa, sb, n;
        bus.lower_in = 8'd100; bus.upper_in = 8'd150;
        frame(2, 1, 150, 99, sa);
        idle(6);
        frame(2, 1, 150, -1, sb);
        idle(6);
        total++;
        if (log_vld[sa+8] !== 1'b1) begin
            bad++; $display("FAIL thr_cur_frame got vld=%0b want 1", log_vld[sa+8]);
        end
        n = 0;
        for (int c = sb; c <= sb + 15; c++) n += int'(log_vld[c]);
        total++;
        if (n !== 0 || log_tab[sb+14] !== 1'b1) begin
            bad++; $display("FAIL thr_next_frame got hits=%0d tab=%0b want 0 1", n, log_tab[sb+14]);
        end
`ifdef MASK_HIT_COUNT_EN
        total++;
        if (log_hc[sa+14] !== 20'd1 || log_hc[sb+14] !== 20'd0) begin
            bad++; $display("FAIL thr_hitcount got %0d then %0d want 1 then 0", log_hc[sa+14], log_hc[sb+14]);
        end
`endif
    endtask

    task automatic test_random;
        int w0, ex, ey, ehc, cut;
        bit abort;
        @(posedge clk); #1 rst = 1'b1; bus.pixel_valid_in = 1'b0; model_reset(cyc);
        @(posedge clk); #1 model_reset(cyc);
        @(posedge clk); #1 rst = 1'b0; w0 = cyc;
        for (int f = 0; f < 16; f++) begin
            bus.lower_in = 8'($urandom_range(60, 140));
            bus.upper_in = 8'($urandom_range(90, 200));
            abort = (f != 15) && ($urandom_range(0, 3) == 0);
            cut   = $urandom_range(1, 10);
            for (int i = 0; i < H * V; i++) begin
                if (abort && i == cut) break;
                while ($urandom_range(0, 3) == 0)
                    px(1'b0, $urandom_range(0, H - 1), $urandom_range(0, V - 1), $urandom_range(0, 255));
                if (i > 0 && $urandom_range(0, 7) == 0)
                    px(1'b1, i % H, i / H, $urandom_range(50, 210), $urandom_range(90, 200));
                else
                    px(1'b1, i % H, i / H, $urandom_range(50, 210));
            end
            if (abort) idle(2);
            else idle($urandom_range(3, 5));
        end
        idle(6);
        ex = 0; ey = 0; ehc = 0;
        for (int c = w0; c < cyc; c++) begin
            if (e_vld[c]) begin ex = e_x[c]; ey = e_y[c]; end
            if (e_hcset[c]) ehc = e_hc[c];
            total++;
            if (log_vld[c] !== e_vld[c]) begin
                bad++; $display("FAIL rnd_vld cyc=%0d got=%0b want=%0b", c, log_vld[c], e_vld[c]);
            end
            total++;
            if (log_tab[c] !== e_tab[c]) begin
                bad++; $display("FAIL rnd_tab cyc=%0d got=%0b want=%0b", c, log_tab[c], e_tab[c]);
            end
            total++;
            if (log_x[c] !== 11'(ex) || log_y[c] !== 10'(ey)) begin
                bad++; $display("FAIL rnd_xy cyc=%0d got=(%0d,%0d) want=(%0d,%0d)", c, log_x[c], log_y[c], ex, ey);
            end
`ifdef MASK_HIT_COUNT_EN
            total++;
            if (log_hc[c] !== 20'(ehc)) begin
                bad++; $display("FAIL rnd_hitcount cyc=%0d got=%0d want=%0d", c, log_hc[c], ehc);
            end
`endif
        end
    endtask

    initial begin
        bus.pixel_valid_in = 1'b0;
        bus.hcount_in      = '0;
        bus.vcount_in      = '0;
        bus.cr_in          = '0;
        bus.lower_in       = 8'd100;
        bus.upper_in       = 8'd150;
        test_reset();
        test_single_hit();
        test_latency_tabulate();
        test_abort();
        test_threshold_change();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
